strhw_stage_seq: RTL and testbench

//  Parametrised Streebog (GOST 34.11-2018) stage sequencer. It accepts message blocks

---
 rtl/strhw_stage_seq_if.sv | 32 +++
 rtl/strhw_stage_seq.sv | 187 ++++++++++++++++++
 tb/tb_strhw_stage_seq.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/strhw_stage_seq_if.sv
// rtl/strhw_stage_seq_if.sv - block feed and g_N engine handshake bundle for the Streebog stage sequencer
interface strhw_stage_seq_if #(
    parameter int BLOCK_W = 512,
    parameter int BYTES_W = $clog2(BLOCK_W/8)+1
);
    // host block feed
    logic               blk_valid_i;
    logic               blk_ready_o;
    logic [BLOCK_W-1:0] block_i;
    logic [BYTES_W-1:0] blk_bytes_i;
    logic               blk_last_i;

    // g_N compression engine
    logic               g_trg_o;
    logic [BLOCK_W-1:0] g_m_o;
    logic [BLOCK_W-1:0] g_n_o;
    logic [BLOCK_W-1:0] g_h_o;
    logic               g_done_i;
    logic [BLOCK_W-1:0] g_result_i;

    // sequencer side
    modport slave (
        input  blk_valid_i, block_i, blk_bytes_i, blk_last_i, g_done_i, g_result_i,
        output blk_ready_o, g_trg_o, g_m_o, g_n_o, g_h_o
    );

    // environment side: block feeder plus g_N core
    modport master (
        output blk_valid_i, block_i, blk_bytes_i, blk_last_i, g_done_i, g_result_i,
        input  blk_ready_o, g_trg_o, g_m_o, g_n_o, g_h_o
    );
endinterface

// File: rtl/strhw_stage_seq.sv
// rtl/strhw_stage_seq.sv - Streebog stage sequencer driving g_N; STRHW_STAGE_SEQ_PERF_EN adds a busy-cycle counter
module strhw_stage_seq #(
    parameter int BLOCK_W = 512,
    parameter int BYTES_W = $clog2(BLOCK_W/8)+1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                mode256_i,
    strhw_stage_seq_if.slave    bus,
    output logic [BLOCK_W-1:0]  digest_o,
    output logic                digest_valid_o,
`ifdef STRHW_STAGE_SEQ_PERF_EN
    output logic [31:0]         perf_cycles_o,
`endif
    output logic                busy_o
);

    localparam logic [BYTES_W-1:0] FULL_BYTES = BYTES_W'(BLOCK_W/8);
    localparam logic [BLOCK_W-1:0] ONE        = BLOCK_W'(1);
    localparam logic [BLOCK_W-1:0] IV_256     = {(BLOCK_W/8){8'h01}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BLK,
        S_G_MSG,
        S_G_LEN,
        S_G_SUM,
        S_DONE
    } state_t;

    state_t             state;
    logic [BLOCK_W-1:0] h_q;
    logic [BLOCK_W-1:0] n_q;
    logic [BLOCK_W-1:0] sigma_q;
    logic [BLOCK_W-1:0] m_q;
    logic [BYTES_W-1:0] bytes_q;
    logic               last_q;
    logic               pad_pend_q;
    logic               armed_q;
    logic               mode256_q;

    logic [BLOCK_W-1:0] pad_bit;
    logic [BLOCK_W-1:0] blk_m;
    logic [BLOCK_W-1:0] n_next;
    logic [BLOCK_W-1:0] sigma_next;
    logic               in_g_state;
    logic               done_ok;
    logic               start_ok;

    // Padding: the marker bit sits just above the valid bytes; for a full block the
    // shift runs off the top, leaving no marker and an all-ones keep mask.
    always_comb begin
        pad_bit    = ONE << {bus.blk_bytes_i, 3'b000};
        blk_m      = (bus.block_i & (pad_bit - ONE)) | pad_bit;
        n_next     = n_q + BLOCK_W'({bytes_q, 3'b000});
        sigma_next = sigma_q + m_q;
    end

    // A done pulse only counts in a g state once that state's trigger has gone out.
    always_comb begin
        in_g_state = (state == S_G_MSG) || (state == S_G_LEN) || (state == S_G_SUM);
        done_ok    = in_g_state && armed_q && bus.g_done_i;
        start_ok   = ((state == S_IDLE) || (state == S_DONE)) && start_i;
    end

    // Ready and busy decode the state register only.
    always_comb begin
        bus.blk_ready_o = (state == S_WAIT_BLK);
        busy_o          = (state != S_IDLE) && (state != S_DONE);
        digest_o        = mode256_q ? {{(BLOCK_W/2){1'b0}}, h_q[BLOCK_W-1:BLOCK_W/2]} : h_q;
    end

    // Stage sequencer: block intake, g_N triggering and h/N/Sigma update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            h_q            <= '0;
            n_q            <= '0;
            sigma_q        <= '0;
            m_q            <= '0;
            bytes_q        <= '0;
            last_q         <= 1'b0;
            pad_pend_q     <= 1'b0;
            armed_q        <= 1'b0;
            mode256_q      <= 1'b0;
            digest_valid_o <= 1'b0;
            bus.g_trg_o    <= 1'b0;
            bus.g_m_o      <= '0;
            bus.g_n_o      <= '0;
            bus.g_h_o      <= '0;
        end else begin
            bus.g_trg_o <= 1'b0;
            if (bus.g_trg_o) begin
                armed_q <= 1'b1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        h_q            <= mode256_i ? IV_256 : '0;
                        n_q            <= '0;
                        sigma_q        <= '0;
                        mode256_q      <= mode256_i;
                        digest_valid_o <= 1'b0;
                        state          <= S_WAIT_BLK;
                    end
                end
                S_WAIT_BLK: begin
                    if (bus.blk_valid_i) begin
                        m_q         <= blk_m;
                        bytes_q     <= bus.blk_bytes_i;
                        last_q      <= bus.blk_last_i;
                        pad_pend_q  <= bus.blk_last_i && (bus.blk_bytes_i == FULL_BYTES);
                        armed_q     <= 1'b0;
                        bus.g_trg_o <= 1'b1;
                        bus.g_h_o   <= h_q;
                        bus.g_n_o   <= n_q;
                        bus.g_m_o   <= blk_m;
                        state       <= S_G_MSG;
                    end
                end
                S_G_MSG: begin
                    if (done_ok) begin
                        armed_q <= 1'b0;
                        h_q     <= bus.g_result_i;
                        sigma_q <= sigma_next;
                        n_q     <= n_next;
                        if (pad_pend_q) begin
                            // A message ending on a full block needs an extra pad-only block.
                            m_q         <= ONE;
                            bytes_q     <= '0;
                            pad_pend_q  <= 1'b0;
                            bus.g_trg_o <= 1'b1;
                            bus.g_h_o   <= bus.g_result_i;
                            bus.g_n_o   <= n_next;
                            bus.g_m_o   <= ONE;
                        end else if (last_q) begin
                            bus.g_trg_o <= 1'b1;
                            bus.g_h_o   <= bus.g_result_i;
                            bus.g_n_o   <= '0;
                            bus.g_m_o   <= n_next;
                            state       <= S_G_LEN;
                        end else begin
                            state <= S_WAIT_BLK;
                        end
                    end
                end
                S_G_LEN: begin
                    if (done_ok) begin
                        armed_q     <= 1'b0;
                        h_q         <= bus.g_result_i;
                        bus.g_trg_o <= 1'b1;
                        bus.g_h_o   <= bus.g_result_i;
                        bus.g_n_o   <= '0;
                        bus.g_m_o   <= sigma_q;
                        state       <= S_G_SUM;
                    end
                end
                S_G_SUM: begin
                    if (done_ok) begin
                        armed_q        <= 1'b0;
                        h_q            <= bus.g_result_i;
                        digest_valid_o <= 1'b1;
                        state          <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef STRHW_STAGE_SEQ_PERF_EN
    // Saturating count of busy cycles, restarted by each accepted start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cycles_o <= '0;
        end else if (start_ok) begin
            perf_cycles_o <= '0;
        end else if (busy_o && (perf_cycles_o != 32'hFFFF_FFFF)) begin
            perf_cycles_o <= perf_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_strhw_stage_seq.sv
// tb/tb_strhw_stage_seq.sv - directed bench for strhw_stage_seq with an XOR g_N stub
module tb_strhw_stage_seq;

    localparam int BW = 512;
    localparam int YW = $clog2(BW/8)+1;

    logic          clk_i;
    logic          rst_i;
    logic          start_i;
    logic          mode256_i;
    logic [BW-1:0] digest_o;
    logic          digest_valid_o;
    logic          busy_o;
`ifdef STRHW_STAGE_SEQ_PERF_EN
    logic [31:0]   perf_cycles_o;
    int            busy_cnt;
`endif

    strhw_stage_seq_if #(.BLOCK_W(BW)) bus ();

    strhw_stage_seq #(.BLOCK_W(BW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .mode256_i      (mode256_i),
        .bus            (bus),
        .digest_o       (digest_o),
        .digest_valid_o (digest_valid_o),
`ifdef STRHW_STAGE_SEQ_PERF_EN
        .perf_cycles_o  (perf_cycles_o),
`endif
        .busy_o         (busy_o)
    );

    int            errors = 0;
    int            checks = 0;

    logic          stub_en;
    logic          stub_done;
    logic [BW-1:0] stub_result;
    int            stub_cnt;
    logic          man_done;
    logic [BW-1:0] man_result;

    logic [BW-1:0] log_m[$];
    logic [BW-1:0] log_n[$];
    logic [BW-1:0] log_h[$];

    logic [BW-1:0] blk_aa;
    logic [BW-1:0] blk_55;
    logic [BW-1:0] iv256;
    logic [BW-1:0] part_in;
    logic [BW-1:0] part_m;

    assign bus.g_done_i   = stub_done | man_done;
    assign bus.g_result_i = man_done ? man_result : stub_result;

    always #5 clk_i = ~clk_i;

    // g_N stub: result = h^m^n, done three cycles after the trigger; also logs operands
    always @(negedge clk_i) begin
        stub_done = 1'b0;
        if (stub_cnt != 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0 && stub_en) stub_done = 1'b1;
        end
        if (bus.g_trg_o) begin
            stub_cnt    = 3;
            stub_result = bus.g_h_o ^ bus.g_m_o ^ bus.g_n_o;
            log_m.push_back(bus.g_m_o);
            log_n.push_back(bus.g_n_o);
            log_h.push_back(bus.g_h_o);
        end
`ifdef STRHW_STAGE_SEQ_PERF_EN
        if (busy_o) busy_cnt = busy_cnt + 1;
`endif
    end

    task automatic clear_log();
        log_m.delete();
        log_n.delete();
        log_h.delete();
    endtask

    task automatic start_msg(input logic m256);
        @(negedge clk_i);
        start_i   = 1'b1;
        mode256_i = m256;
        clear_log();
`ifdef STRHW_STAGE_SEQ_PERF_EN
        busy_cnt = 0;
`endif
        @(negedge clk_i);
        start_i   = 1'b0;
    endtask

    task automatic send_block(input logic [BW-1:0] blk, input logic [YW-1:0] nb, input logic last);
        int t;
        bus.blk_valid_i = 1'b1;
        bus.block_i     = blk;
        bus.blk_bytes_i = nb;
        bus.blk_last_i  = last;
        t = 0;
        while (!bus.blk_ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL blk_accept_timeout: ready=%0b after %0d cycles, required 1", bus.blk_ready_o, t);
        end
        @(negedge clk_i);
        bus.blk_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!digest_valid_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        checks++;
        if (!digest_valid_o) begin
            errors++;
            $display("FAIL digest_timeout: digest_valid_o=%0b after %0d cycles, required 1", digest_valid_o, t);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({bus.g_trg_o, bus.blk_ready_o, digest_valid_o, busy_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {bus.g_trg_o, bus.blk_ready_o, digest_valid_o, busy_o});
        end
        checks++;
        if ((bus.g_m_o | bus.g_n_o | bus.g_h_o | digest_o) !== '0) begin
            errors++;
            $display("FAIL reset_buses: got nonzero operand/digest, required 0");
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_empty_512();
        start_msg(1'b0);
        send_block('0, 7'd0, 1'b1);
        wait_done();
        checks++;
        if (log_m.size() !== 3) begin
            errors++;
            $display("FAIL empty_trig_count: got %0d required 3", log_m.size());
        end
        checks++;
        if (log_m[0] !== BW'(1) || log_m[1] !== BW'(0) || log_m[2] !== BW'(1)) begin
            errors++;
            $display("FAIL empty_m_seq: got %0h,%0h,%0h required 1,0,1", log_m[0], log_m[1], log_m[2]);
        end
        checks++;
        if ((log_n[0] | log_n[1] | log_n[2]) !== '0) begin
            errors++;
            $display("FAIL empty_n_seq: got %0h,%0h,%0h required 0,0,0", log_n[0], log_n[1], log_n[2]);
        end
        checks++;
        if (digest_o !== '0 || digest_valid_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_digest: got %0h valid=%0b busy=%0b required 0 valid=1 busy=0", digest_o, digest_valid_o, busy_o);
        end
    endtask

    task automatic test_full_block();
        start_msg(1'b0);
        send_block(blk_aa, 7'd64, 1'b1);
        wait_done();
        checks++;
        if (log_m.size() !== 4) begin
            errors++;
            $display("FAIL full_trig_count: got %0d required 4", log_m.size());
        end
        checks++;
        if (log_m[0] !== blk_aa || log_m[1] !== BW'(1) || log_m[2] !== BW'(512) || log_m[3] !== blk_aa + BW'(1)) begin
            errors++;
            $display("FAIL full_m_seq: got %0h,%0h,%0h,%0h", log_m[0], log_m[1], log_m[2], log_m[3]);
        end
        checks++;
        if (log_n[0] !== '0 || log_n[1] !== BW'(512) || log_n[2] !== '0 || log_n[3] !== '0) begin
            errors++;
            $display("FAIL full_n_seq: got %0h,%0h,%0h,%0h required 0,200,0,0", log_n[0], log_n[1], log_n[2], log_n[3]);
        end
        checks++;
        if (log_h[1] !== blk_aa || log_h[3] !== (blk_aa ^ BW'(1))) begin
            errors++;
            $display("FAIL full_h_seq: got %0h,%0h", log_h[1], log_h[3]);
        end
        checks++;
        if (digest_o !== '0) begin
            errors++;
            $display("FAIL full_digest: got %0h required 0", digest_o);
        end
    endtask

    task automatic test_partial();
        start_msg(1'b0);
        send_block(part_in, 7'd3, 1'b1);
        wait_done();
        checks++;
        if (log_m.size() !== 3 || log_m[0] !== part_m || log_m[1] !== BW'(24) || log_m[2] !== part_m) begin
            errors++;
            $display("FAIL partial_m_seq: got n=%0d %0h,%0h,%0h required 3 1112233,18,1112233", log_m.size(), log_m[0], log_m[1], log_m[2]);
        end
        checks++;
        if (digest_o !== BW'(24)) begin
            errors++;
            $display("FAIL partial_digest: got %0h required 18", digest_o);
        end
    endtask

    task automatic test_mode256();
        start_msg(1'b1);
        checks++;
        if (digest_valid_o !== 1'b0 || bus.blk_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL m256_after_start: valid=%0b ready=%0b required 0 1", digest_valid_o, bus.blk_ready_o);
        end
        send_block('0, 7'd0, 1'b1);
        wait_done();
        checks++;
        if (log_h[0] !== iv256) begin
            errors++;
            $display("FAIL m256_first_h: got %0h required %0h", log_h[0], iv256);
        end
        checks++;
        if (digest_o[511:256] !== 256'h0 || digest_o[255:0] !== iv256[511:256]) begin
            errors++;
            $display("FAIL m256_digest: got %0h required %0h", digest_o, iv256[511:256]);
        end
    endtask

    task automatic test_back_to_back();
        start_msg(1'b0);
        send_block(blk_55, 7'd64, 1'b0);
        send_block('0, 7'd0, 1'b1);
        wait_done();
        checks++;
        if (log_m.size() !== 4 || log_m[1] !== BW'(1) || log_n[1] !== BW'(512) || log_h[1] !== blk_55) begin
            errors++;
            $display("FAIL b2b_second_trig: n=%0d m=%0h nn=%0h h=%0h", log_m.size(), log_m[1], log_n[1], log_h[1]);
        end
        checks++;
        if (digest_o !== BW'(2)) begin
            errors++;
            $display("FAIL b2b_digest: got %0h required 2", digest_o);
        end
    endtask

    task automatic test_busy_hold();
        stub_en = 1'b0;
        start_msg(1'b0);
        send_block(blk_55, 7'd64, 1'b0);
        bus.blk_valid_i = 1'b1;
        bus.block_i     = '0;
        bus.blk_bytes_i = 7'd0;
        bus.blk_last_i  = 1'b1;
        start_i         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.blk_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL hold_ready_%0d: ready=%0b busy=%0b required 0 1", i, bus.blk_ready_o, busy_o);
            end
            @(negedge clk_i);
            start_i = 1'b0;
        end
        checks++;
        if (log_m.size() !== 1) begin
            errors++;
            $display("FAIL hold_trig_count: got %0d required 1", log_m.size());
        end
        stub_en    = 1'b1;
        man_result = blk_55;
        man_done   = 1'b1;
        @(negedge clk_i);
        man_done   = 1'b0;
        @(negedge clk_i);
        bus.blk_valid_i = 1'b0;
        wait_done();
        checks++;
        if (log_m.size() !== 4 || log_h[1] !== blk_55 || log_m[1] !== BW'(1) || log_n[1] !== BW'(512)) begin
            errors++;
            $display("FAIL hold_resume: n=%0d h=%0h m=%0h nn=%0h", log_m.size(), log_h[1], log_m[1], log_n[1]);
        end
        checks++;
        if (digest_o !== BW'(2)) begin
            errors++;
            $display("FAIL hold_digest: got %0h required 2", digest_o);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        start_msg(1'b0);
        send_block('0, 7'd0, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++;
        if ({bus.g_trg_o, bus.blk_ready_o, digest_valid_o, busy_o} !== 4'b0000 ||
            (bus.g_m_o | bus.g_n_o | bus.g_h_o | digest_o) !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: flags=%b m=%0h required all 0", {bus.g_trg_o, bus.blk_ready_o, digest_valid_o, busy_o}, bus.g_m_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        n0 = log_m.size();
        repeat (8) @(negedge clk_i);
        checks++;
        if (log_m.size() !== n0 || busy_o !== 1'b0 || bus.blk_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_late_done: trig %0d->%0d busy=%0b ready=%0b required no trigger, idle", n0, log_m.size(), busy_o, bus.blk_ready_o);
        end
    endtask

`ifdef STRHW_STAGE_SEQ_PERF_EN
    task automatic test_perf();
        start_msg(1'b0);
        send_block('0, 7'd0, 1'b1);
        wait_done();
        checks++;
        if (perf_cycles_o !== 32'(busy_cnt)) begin
            errors++;
            $display("FAIL perf_count: got %0d required %0d", perf_cycles_o, busy_cnt);
        end
        start_msg(1'b0);
        checks++;
        if (perf_cycles_o !== 32'd0) begin
            errors++;
            $display("FAIL perf_clear: got %0d required 0", perf_cycles_o);
        end
    endtask
`endif

    initial begin
        clk_i           = 1'b0;
        rst_i           = 1'b1;
        start_i         = 1'b0;
        mode256_i       = 1'b0;
        bus.blk_valid_i = 1'b0;
        bus.block_i     = '0;
        bus.blk_bytes_i = '0;
        bus.blk_last_i  = 1'b0;
        stub_en         = 1'b1;
        stub_done       = 1'b0;
        stub_result     = '0;
        stub_cnt        = 0;
        man_done        = 1'b0;
        man_result      = '0;
`ifdef STRHW_STAGE_SEQ_PERF_EN
        busy_cnt        = 0;
`endif
        blk_aa  = {64{8'hAA}};
        blk_55  = {64{8'h55}};
        iv256   = {64{8'h01}};
        part_in = {{61{8'hEE}}, 24'h112233};
        part_m  = BW'(32'h0111_2233);

        test_reset();
        test_empty_512();
        test_full_block();
        test_partial();
        test_mode256();
        test_back_to_back();
        test_busy_hold();
        test_reset_mid();
`ifdef STRHW_STAGE_SEQ_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
